// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : round-robin write/read arbitration onto one memory port
//                    pair, with a one-cycle read response and hazard bypass.
// Revision 1.0
// ============================================================================

module mem_port_arbiter_rr #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Two passes: requesters at or above the pointer first, then the wrap.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        if (!any_o && req_i[j] && (j >= int'(ptr_q))) begin
          any_o    = 1'b1;
          idx_o    = IW'(j);
          gnt_o[j] = 1'b1;
        end
      end
      for (int j = 0; j < N; j++) begin
        if (!any_o && req_i[j]) begin
          any_o    = 1'b1;
          idx_o    = IW'(j);
          gnt_o[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_o) begin
      ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

module mem_port_arbiter #(
  parameter int DATAW = 128,
  parameter int DEPTH = 64,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int NWR   = 2,
  parameter int NRD   = 4,
  parameter int IDW   = (NRD > 1) ? $clog2(NRD) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NWR-1:0]         wr_req,
  input  logic [NWR*ADDRW-1:0]   wr_addr,
  input  logic [NWR*DATAW-1:0]   wr_data,
  output logic [NWR-1:0]         wr_gnt,
  input  logic [NRD-1:0]         rd_req,
  input  logic [NRD*ADDRW-1:0]   rd_addr,
  output logic [NRD-1:0]         rd_gnt,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATAW-1:0]       rsp_data,
  output logic [ADDRW-1:0]       mem_waddr,
  output logic                   mem_wen,
  output logic [DATAW-1:0]       mem_wdata,
  output logic [ADDRW-1:0]       mem_raddr,
  input  logic [DATAW-1:0]       mem_rdata
);

  localparam int WIW = (NWR > 1) ? $clog2(NWR) : 1;

  logic [WIW-1:0]   wr_idx;
  logic             wr_any;
  logic [IDW-1:0]   rd_idx;
  logic             rd_any;

  logic             rd_v_q, rd_v_d;
  logic [IDW-1:0]   rd_id_q, rd_id_d;
  logic             byp_q, byp_d;
  logic [DATAW-1:0] byp_data_q, byp_data_d;

  mem_port_arbiter_rr #(.N(NWR), .IW(WIW)) u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (wr_req),
    .gnt_o (wr_gnt),
    .idx_o (wr_idx),
    .any_o (wr_any)
  );

  mem_port_arbiter_rr #(.N(NRD), .IW(IDW)) u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (rd_req),
    .gnt_o (rd_gnt),
    .idx_o (rd_idx),
    .any_o (rd_any)
  );

  // Grant vectors are one-hot-or-zero, so an OR-select leaves 0 when idle.
  always_comb begin
    mem_waddr = '0;
    mem_wdata = '0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_gnt[i]) begin
        mem_waddr = wr_addr[i*ADDRW +: ADDRW];
        mem_wdata = wr_data[i*DATAW +: DATAW];
      end
    end
  end

  always_comb begin
    mem_raddr = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_gnt[i]) begin
        mem_raddr = rd_addr[i*ADDRW +: ADDRW];
      end
    end
  end

  assign mem_wen = wr_any;

  // The memory returns the old word on a same-edge write, so capture the new one.
  always_comb begin
    rd_v_d     = rd_any;
    rd_id_d    = rd_any ? rd_idx : '0;
    byp_d      = rd_any && wr_any && (mem_waddr == mem_raddr);
    byp_data_d = byp_d ? mem_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v_q     <= 1'b0;
      rd_id_q    <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_v_q     <= rd_v_d;
      rd_id_q    <= rd_id_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign rsp_valid = rd_v_q;
  assign rsp_id    = rd_v_q ? rd_id_q : '0;
  assign rsp_data  = !rd_v_q ? '0 : (byp_q ? byp_data_q : mem_rdata);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed scenarios plus held-until-granted random
//                       traffic against a queue/array reference model.
// Revision 1.0
// ============================================================================

module tb_mem_port_arbiter;

  localparam int DATAW = 128;
  localparam int DEPTH = 64;
  localparam int ADDRW = 6;
  localparam int NWR   = 2;
  localparam int NRD   = 4;
  localparam int IDW   = 2;

  logic                 clk;
  logic                 rst;
  logic [NWR-1:0]       wr_req;
  logic [NWR*ADDRW-1:0] wr_addr;
  logic [NWR*DATAW-1:0] wr_data;
  logic [NWR-1:0]       wr_gnt;
  logic [NRD-1:0]       rd_req;
  logic [NRD*ADDRW-1:0] rd_addr;
  logic [NRD-1:0]       rd_gnt;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [DATAW-1:0]     rsp_data;
  logic [ADDRW-1:0]     mem_waddr;
  logic                 mem_wen;
  logic [DATAW-1:0]     mem_wdata;
  logic [ADDRW-1:0]     mem_raddr;
  logic [DATAW-1:0]     mem_rdata;

  mem_port_arbiter #(
    .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW),
    .NWR(NWR), .NRD(NRD), .IDW(IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .mem_waddr (mem_waddr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: registered read, old word on a same-edge write.
  logic [DATAW-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wen) env_mem[mem_waddr] <= mem_wdata;
    mem_rdata <= env_mem[mem_raddr];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int rr_pick(input logic [7:0] req, input int n, input int ptr);
    for (int k = 0; k < n; k++) begin
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  // Reference model state
  logic [DATAW-1:0] ref_mem [DEPTH];
  int               m_wptr, m_rptr;
  bit               p_v;
  int               p_id;
  logic [DATAW-1:0] p_data;
  int               ew, er;
  logic [ADDRW-1:0] ea_w, ea_r;
  logic [DATAW-1:0] ed_w;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_gnt",   {wr_gnt, rd_gnt}, '0);
      chk("rst_mem",   {mem_wen, mem_waddr, mem_raddr}, '0);
      chk("rst_wdata", mem_wdata, '0);
      chk("rst_rsp",   {rsp_valid, rsp_id}, '0);
      chk("rst_rdata", rsp_data, '0);
      m_wptr = 0;
      m_rptr = 0;
      p_v    = 0;
      p_id   = 0;
      p_data = '0;
    end else begin
      ew   = rr_pick(8'(wr_req), NWR, m_wptr);
      er   = rr_pick(8'(rd_req), NRD, m_rptr);
      ea_w = (ew >= 0) ? wr_addr[ew*ADDRW +: ADDRW] : '0;
      ed_w = (ew >= 0) ? wr_data[ew*DATAW +: DATAW] : '0;
      ea_r = (er >= 0) ? rd_addr[er*ADDRW +: ADDRW] : '0;
      chk("wr_gnt",    wr_gnt, (ew >= 0) ? (DATAW'(1) << ew) : '0);
      chk("mem_wen",   mem_wen, (ew >= 0) ? 1 : 0);
      chk("mem_waddr", mem_waddr, ea_w);
      chk("mem_wdata", mem_wdata, ed_w);
      chk("rd_gnt",    rd_gnt, (er >= 0) ? (DATAW'(1) << er) : '0);
      chk("mem_raddr", mem_raddr, ea_r);
      chk("rsp_valid", rsp_valid, p_v);
      chk("rsp_id",    rsp_id, p_v ? p_id : 0);
      chk("rsp_data",  rsp_data, p_v ? p_data : '0);
      // Next-cycle response is decided before this cycle's write lands.
      p_v    = (er >= 0);
      p_id   = (er >= 0) ? er : 0;
      p_data = (er < 0) ? '0 : ((ew >= 0 && ea_w == ea_r) ? ed_w : ref_mem[ea_r]);
      if (ew >= 0) begin
        ref_mem[ea_w] = ed_w;
        m_wptr = (ew + 1) % NWR;
      end
      if (er >= 0) m_rptr = (er + 1) % NRD;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    wr_req = '0;
    rd_req = '0;
  endtask

  task automatic set_w(input int i, input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
    wr_addr[i*ADDRW +: ADDRW] = a;
    wr_data[i*DATAW +: DATAW] = d;
  endtask

  task automatic set_r(input int i, input logic [ADDRW-1:0] a);
    rd_addr[i*ADDRW +: ADDRW] = a;
  endtask

  logic [NWR-1:0] g_w;
  logic [NRD-1:0] g_r;

  initial begin
    rst = 1'b1;
    clr_in();
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = {4{32'(i) ^ 32'hC0DE_0000}};
      ref_mem[i] = {4{32'(i) ^ 32'hC0DE_0000}};
    end
    #1 rst = 1'b0;

    // Requests are ignored while reset is held
    cyc();
    wr_req = '1;
    rd_req = '1;
    cyc();
    @(negedge clk);
    chk("lit_rst_gnt", {wr_gnt, rd_gnt, mem_wen, rsp_valid}, '0);
    cyc();
    rst = 1'b1;
    clr_in();
    @(negedge clk);

    // Write then read through memory
    cyc();
    wr_req = 2'b10;
    set_w(1, 6'd5, 'hA5);
    @(negedge clk);
    chk("lit_wr_gnt_1", wr_gnt, 2'b10);
    chk("lit_waddr_5", {mem_wen, mem_waddr, mem_wdata[7:0]}, {1'b1, 6'd5, 8'hA5});
    cyc();
    wr_req = '0;
    rd_req = 4'b0100;
    set_r(2, 6'd5);
    @(negedge clk);
    chk("lit_rd_gnt_2", {rd_gnt, mem_raddr}, {4'b0100, 6'd5});
    cyc();
    rd_req = '0;
    @(negedge clk);
    chk("lit_rsp_wr_rd", {rsp_valid, rsp_id}, {1'b1, 2'd2});
    chk("lit_rsp_a5", rsp_data, 'hA5);

    // Same-cycle hazard on addr 9
    cyc();
    wr_req = 2'b01;
    set_w(0, 6'd9, 'h11);
    @(negedge clk);
    cyc();
    wr_req = 2'b01;
    set_w(0, 6'd9, 'h22);
    rd_req = 4'b0001;
    set_r(0, 6'd9);
    @(negedge clk);
    chk("lit_hz_gnt", {wr_gnt, rd_gnt}, {2'b01, 4'b0001});
    cyc();
    clr_in();
    @(negedge clk);
    chk("lit_hz_bypass", rsp_data, 'h22);
    cyc();
    rd_req = 4'b0001;
    @(negedge clk);
    cyc();
    rd_req = '0;
    @(negedge clk);
    chk("lit_hz_later", rsp_data, 'h22);

    // Fresh reset, then all requesters contend
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    for (int i = 0; i < NRD; i++) set_r(i, ADDRW'(20 + i));
    set_w(0, 6'd40, 'h40);
    set_w(1, 6'd41, 'h41);
    for (int i = 0; i < 8; i++) begin
      rd_req = '1;
      wr_req = (i < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
      chk("lit_rr_rd", rd_gnt, 4'b0001 << (i % 4));
      if (i < 4) chk("lit_rr_wr", {wr_gnt, mem_wen}, {((i % 2) != 0) ? 2'b10 : 2'b01, 1'b1});
      if (i > 0) chk("lit_rr_rsp", {rsp_valid, rsp_id}, {1'b1, 2'((i - 1) % 4)});
      cyc();
    end
    clr_in();
    @(negedge clk);
    chk("lit_rr_last", {rsp_valid, rsp_id}, {1'b1, 2'd3});

    // Reset after a read grant suppresses its response
    cyc();
    rd_req = 4'b0010;
    @(negedge clk);
    chk("lit_pre_rst", rd_gnt, 4'b0010);
    #2 rst = 1'b0;
    cyc();
    rd_req = '0;
    @(negedge clk);
    chk("lit_rst_norsp", rsp_valid, 1'b0);
    cyc();
    rst = 1'b1;
    rd_req = 4'b1001;
    wr_req = 2'b01;
    @(negedge clk);
    chk("lit_post_rst", {rd_gnt, wr_gnt}, {4'b0001, 2'b01});

    // Idle keeps pointers
    cyc();
    clr_in();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      cyc();
      @(negedge clk);
      chk("lit_idle", {wr_gnt, rd_gnt, mem_wen, rsp_valid}, '0);
      chk("lit_idle_data", rsp_data, '0);
    end
    cyc();
    rd_req = 4'b1001;
    wr_req = 2'b11;
    @(negedge clk);
    chk("lit_idle_order", {rd_gnt, wr_gnt}, {4'b1000, 2'b10});

    // Random traffic, requests held until granted, occasional reset
    g_w = '1;
    g_r = '1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NWR; i++) begin
        if (!wr_req[i] || g_w[i]) begin
          wr_req[i] = ($urandom_range(0, 2) != 0);
          set_w(i, ADDRW'($urandom_range(0, 7)), {$urandom(), $urandom(), $urandom(), $urandom()});
        end
      end
      for (int i = 0; i < NRD; i++) begin
        if (!rd_req[i] || g_r[i]) begin
          rd_req[i] = ($urandom_range(0, 1) != 0);
          set_r(i, ADDRW'($urandom_range(0, 7)));
        end
      end
      @(negedge clk);
      g_w = wr_gnt;
      g_r = rd_gnt;
    end

    cyc();
    rst = 1'b1;
    clr_in();
    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: DATAW, default 128, word width; DEPTH, default 64, words; ADDRW, default $clog2(DEPTH), address width; NWR, default 2, write requesters; NRD, default 4, read requesters; IDW, default max(1,$clog2(NRD)), response ID width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_req  in  NWR  write request per requester, level, held until granted.
- wr_addr  in  NWR*ADDRW  packed write addresses; requester i at slice i.
- wr_data  in  NWR*DATAW  packed write data.
- wr_gnt  out  NWR  one-hot-or-zero write grant; the write is accepted this cycle.
- rd_req  in  NRD  read request per requester, level, held until granted.
- rd_addr  in  NRD*ADDRW  packed read addresses.
- rd_gnt  out  NRD  one-hot-or-zero read grant.
- rsp_valid  out  1  read response valid, one-cycle pulse.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  DATAW  read data.
- mem_waddr, mem_wen, mem_wdata  out  ADDRW/1/DATAW  drive the memory write port.
- mem_raddr  out  ADDRW  drives the memory read address.
- mem_rdata  in  DATAW  registered memory read data; valid one cycle after the address is presented; returns the old word on a same-edge write.

Function
REQ-003 Write and read arbitration SHALL be independent; one write and one read SHALL be granted in the same cycle when both are requested.
REQ-004 Each port SHALL use a registered round-robin pointer. Grant is combinational from req and the pointer: the first requester at or after the pointer, in increasing index with wrap to 0.
REQ-005 After a grant to requester k, the pointer SHALL become (k+1) mod N. With no grant, the pointer SHALL be unchanged.
REQ-006 A requester with continuous req SHALL be granted within N cycles (no starvation).
REQ-007 mem_wen SHALL equal |wr_gnt. mem_waddr and mem_wdata SHALL carry the granted slice, or 0 when there is no write grant.
REQ-008 mem_raddr SHALL carry the granted read address, or 0 when there is no read grant.
REQ-009 A read granted in cycle N SHALL produce rsp_valid=1 in cycle N+1, with rsp_id equal to the granted index. Fixed latency is 1; there is no response backpressure.
REQ-010 Hazard bypass: if a write and a read to the same address are granted in the same cycle, the cycle N+1 rsp_data SHALL be the written data, not mem_rdata.
REQ-011 Otherwise rsp_data SHALL equal mem_rdata when rsp_valid=1.
REQ-012 rsp_id and rsp_data SHALL be 0 whenever rsp_valid=0.
REQ-013 A write granted in cycle N followed by a read of the same address granted in cycle N+1 SHALL return the new data through the memory, with no bypass.
REQ-014 Pipeline state SHALL be: rd_v_q, rd_id_q, byp_q and byp_data_q, all updated every cycle.
REQ-015 Out-of-range addresses (>= DEPTH) SHALL be passed through unchanged; the controller does no checking.

Reset
REQ-016 While rst=0: all grants, mem_wen, mem_waddr, mem_wdata, mem_raddr, rsp_valid, rsp_id and rsp_data SHALL be 0, regardless of requests.
REQ-017 On assertion of rst=0, both pointers SHALL be 0 and all pipeline registers SHALL be 0, asynchronously.
REQ-018 A read granted in the cycle before a mid-operation reset SHALL produce no response.
REQ-019 On the first rising edge after rst returns to 1, arbitration SHALL resume with requester 0 at highest priority.

Verification
REQ-020 Write then read: requester 1 writes addr 5 = 0xA5 in cycle 0, read requester 2 reads addr 5 in cycle 1 -> rsp_valid=1, rsp_id=2, rsp_data=0xA5 in cycle 2.
REQ-021 Same-cycle hazard: addr 9 holds 0x11; write 0x22 to addr 9 and read addr 9 granted in the same cycle -> next-cycle rsp_data=0x22, and a later read of addr 9 returns 0x22.
REQ-022 Round robin: all 4 read requesters held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, one response per cycle with matching rsp_id.
REQ-023 Write fairness: both write requesters high for 4 cycles -> wr_gnt 01,10,01,10, and mem_wen=1 in each of those cycles.
REQ-024 Reset mid-operation: read granted in cycle N, rst driven low before edge N+1 -> rsp_valid stays 0. After release, requester 0 wins a 0/3 contest.
REQ-025 Idle: no requests for 10 cycles -> all grants, mem_wen, rsp_valid and rsp_data are 0, and the pointers are unchanged (checked by the next contest order).
